aes256_key_sched_ctrl: RTL
==========================

# aes256_key_sched_ctrl

Sequential AES-256 key-expansion controller. It captures a 256-bit cipher key and generates the 15 round keys (RK0..RK14, 128 bits each) one word per cycle, using RotWord, SubWord and Rcon. It streams each round key to the cipher datapath over a valid/ready handshake. It sits between the key register and the round pipeline, so no 60-word key RAM is needed.

## Interface
- No parameters; AES-256 fixed (Nk=8, Nr=14).
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin expansion of key; sampled only in IDLE.
- abort  in  1  synchronous cancel; return to IDLE next edge, no done.
- key  in  256  cipher key; key[255:224] = w0 … key[31:0] = w7; captured on the start cycle only.
- busy  out  1  high in every state except IDLE.
- rk_valid  out  1  round key on rk_data is valid.
- rk_ready  in  1  consumer accepts; handshake = rk_valid & rk_ready.
- rk_index  out  4  round number of rk_data, 0..14.
- rk_data  out  128  round key, {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- done  out  1  one-cycle pulse after RK14 handshake.

## Operation
- Window: 8-word shift register holding w[i-8]..w[i-1]. Word counter i is 6 bits, 8..59. Round counter r is 4 bits, 0..14.
- Next word: w[i] = w[i-8] ^ temp.
  - i%8==0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/8], 24'h0}. Rcon[1..7] = 01,02,04,08,10,20,40.
  - i%8==4: temp = SubWord(w[i-1]).
  - otherwise: temp = w[i-1].
- Each GEN cycle shifts w[i] in, drops w[i-8] and increments i.
- FSM states: IDLE, OUT, GEN.
  - IDLE, start=1: load window with key, i=8, r=0, go to OUT.
  - OUT: rk_valid=1. On handshake:
    - r==14: go to IDLE and pulse done.
    - r==0: r=1, stay in OUT.
    - else: r+1, go to GEN.
  - GEN: exactly 4 cycles (i advances 4), then go to OUT.
- rk_data = oldest 4 window words when r==0, otherwise newest 4 words.
- rk_index = r while in OUT.
- abort in any state: next state IDLE. Counters and window are left as-is, rk_valid drops, no done.
- abort and start in the same IDLE cycle: abort wins; nothing starts.
- start while busy: ignored; the key is not recaptured.
- Changes on key after capture have no effect.

## Timing
- Reset values: busy=0, rk_valid=0, rk_index=0, rk_data=0, done=0. State is IDLE; window, i and r are 0.
- Start latency: start high at edge N gives rk_valid=1 with RK0 after edge N+1.
- RK1 follows 1 cycle after the RK0 handshake.
- RKr for r≥2 is valid 5 cycles after the RK(r-1) handshake: 4 GEN cycles plus entry to OUT.
- With rk_ready held high: RKr is valid in cycle 2+5(r-1) for r≥1 (start = cycle 0). RK14 is in cycle 67 and done in cycle 68; busy falls in cycle 68.
- Backpressure: while rk_valid & !rk_ready, rk_valid, rk_index and rk_data hold stable and no GEN occurs.
- Mid-operation reset: immediate return to reset values, independent of clk.
- Next start is accepted in the same cycle done pulses, since the state is already IDLE.

## Structure
- Shared package aes_pkg holds:
  - Rcon table as a constant array indexed 1..7;
  - state enum {IDLE, OUT, GEN};
  - constants NR=14, NK=8, LAST_WORD=59.
- Reuse the existing RotWord module and the existing sub_word (4× S-box) module.
- One new combinational sub-module, key_word_next: inputs w[i-8], w[i-1], i[2:0], Rcon byte; output w[i]. It instantiates RotWord and sub_word. All sequencing stays in the top-level block.

## Test plan
- FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, rk_ready=1:
  - RK0 = 603deb1015ca71be2b73aef0857d7781;
  - RK1 = 1f352c073b6108d72d9810a30914dff4;
  - RK2 = 9ba354118e6925afa51a8b5f2067fcde;
  - RK14 = fe4890d1e6188d0b046df344706c631e in cycle 67, done in cycle 68.
- Same key, rk_ready random with 50% duty: identical 15 keys in order. rk_data and rk_index are stable during every stalled cycle, and there is exactly one done pulse.
- abort asserted in the 2nd GEN cycle of round 5: busy=0 and rk_valid=0 next cycle, no done. A following start produces a correct RK0..RK14.
- rst_n pulled low while RK7 is stalled: all outputs go to 0 asynchronously. After release the block stays idle until start.
- Second start pulse during busy, with a different key: ignored; the round-key stream still matches the first key.
- Key all-zero: RK2 = 62636363626363636263636362636363.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: S-box, round constants, key-schedule FSM states.
package aes_pkg;
  localparam int NR        = 14;
  localparam int NK        = 8;
  localparam int LAST_WORD = 59;

  typedef enum logic [1:0] {IDLE, OUT, GEN} state_t;

  localparam logic [7:0] RCON [1:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction
endpackage

// File: rtl/aes256_key_sched_ctrl_key_word_next.sv
// key_word_next: combinational AES-256 expansion step, w[i] from w[i-8], w[i-1].
module key_word_next (
  input  logic [31:0] w_old,
  input  logic [31:0] w_prev,
  input  logic [2:0]  imod,
  input  logic [7:0]  rcon,
  output logic [31:0] w_new
);
  logic [31:0] rot, sw_in, sw_out, temp;

  rot_word u_rot (.din(w_prev), .dout(rot));

  // One S-box bank serves both the rotated (i%8==0) and plain (i%8==4) cases
  assign sw_in = (imod == 3'd0) ? rot : w_prev;

  sub_word u_sub (.din(sw_in), .dout(sw_out));

  always_comb begin
    temp = w_prev;
    if (imod == 3'd0)      temp = sw_out ^ {rcon, 24'h0};
    else if (imod == 3'd4) temp = sw_out;
  end

  assign w_new = w_old ^ temp;
endmodule

// File: rtl/rot_word.sv
// RotWord: cyclic left rotate of a key word by one byte.
module rot_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  assign dout = {din[23:0], din[31:24]};
endmodule

// File: rtl/sub_word.sv
// SubWord: four parallel S-box lookups, one per byte lane.
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign dout[8*g+7:8*g] = sbox(din[8*g+7:8*g]);
  end
endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key expansion controller: 8-word sliding window, streams RK0..RK14
// over a valid/ready handshake, one new word generated per GEN cycle.
module aes256_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic [127:0] rk_data,
  output logic         done
);
  state_t           st;
  logic [0:7][31:0] win;   // win[0] = w[i-8] (oldest), win[7] = w[i-1]
  logic [5:0]       i;
  logic [3:0]       r;
  logic [1:0]       gcnt;
  logic [31:0]      wnext;
  logic [7:0]       rcon_b;
  logic             hs;

  assign hs     = rk_valid & rk_ready;
  assign rcon_b = (i[5:3] == 3'd0) ? 8'h00 : RCON[i[5:3]];

  key_word_next u_kwn (
    .w_old (win[0]),
    .w_prev(win[7]),
    .imod  (i[2:0]),
    .rcon  (rcon_b),
    .w_new (wnext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      win      <= '0;
      i        <= '0;
      r        <= '0;
      gcnt     <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_index <= '0;
      rk_data  <= '0;
      done     <= 1'b0;
    end else if (abort) begin
      st       <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          win      <= key;
          i        <= 6'(NK);
          r        <= '0;
          gcnt     <= '0;
          st       <= OUT;
          busy     <= 1'b1;
          rk_valid <= 1'b1;
          rk_index <= '0;
          rk_data  <= key[255:128];
        end
        OUT: if (hs) begin
          if (r == 4'(NR)) begin
            st       <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b1;
          end else if (r == 4'd0) begin
            // RK1 is the second key half, already sitting in the window
            r        <= 4'd1;
            rk_index <= 4'd1;
            rk_data  <= win[4:7];
          end else begin
            r        <= r + 4'd1;
            st       <= GEN;
            rk_valid <= 1'b0;
            gcnt     <= '0;
          end
        end
        GEN: begin
          win  <= {win[1:7], wnext};
          if (i != 6'(LAST_WORD)) i <= i + 6'd1;
          gcnt <= gcnt + 2'd1;
          if (gcnt == 2'd3) begin
            st       <= OUT;
            rk_valid <= 1'b1;
            rk_index <= r;
            rk_data  <= {win[5:7], wnext};
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
